// File: rtl/mont_pkg.sv
// Shared encodings for the Montgomery multiplier control path: FSM states,
// adder input-mux selects and the idle chunk code.
package mont_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ADD_B   = 3'd1;
   localparam logic [2:0] ST_ADD_M   = 3'd2;
   localparam logic [2:0] ST_RESOLVE = 3'd3;
   localparam logic [2:0] ST_SUB     = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   localparam logic [1:0] SEL_ZERO  = 2'd0;
   localparam logic [1:0] SEL_B     = 2'd1;
   localparam logic [1:0] SEL_M     = 2'd2;
   localparam logic [1:0] SEL_NEG_M = 2'd3;

   // Bit 3 set freezes the adder's chunk carry chain.
   localparam logic [3:0] CHUNK_IDLE = 4'd8;

endpackage

// File: rtl/mont_mul_sequencer.sv
// Control FSM sequencing the carry-save Montgomery adder through bit-serial
// accumulate/reduce, chunked carry resolution and repeated subtraction of M.
module mont_mul_sequencer
   import mont_pkg::*;
#(
   parameter int unsigned N_BITS     = 512,
   parameter int unsigned CHUNKS     = 5,
   parameter int unsigned MAX_PASSES = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       a_bit,
   input  logic       c_zero,
   input  logic       sub_done,
   output logic [9:0] bit_idx,
   output logic       enable_c,
   output logic       shift_c,
   output logic       subtract,
   output logic [3:0] chunk_sel,
   output logic [1:0] in_sel,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned PASS_W = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;

   localparam logic [9:0]        LAST_BIT   = 10'(N_BITS - 1);
   localparam logic [3:0]        LAST_CHUNK = 4'(CHUNKS - 1);
   localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'(MAX_PASSES - 1);

   logic [2:0]        state_q, state_d;
   logic [9:0]        bit_idx_q, bit_idx_d;
   logic [3:0]        chunk_q, chunk_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic              err_q, err_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= 10'd0;
         chunk_q   <= 4'd0;
         pass_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         chunk_q   <= chunk_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      chunk_d   = chunk_q;
      pass_d    = pass_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ADD_B;
               bit_idx_d = 10'd0;
               err_d     = 1'b0;
            end
         end
         ST_ADD_B: state_d = ST_ADD_M;
         ST_ADD_M: begin
            if (bit_idx_q == LAST_BIT) begin
               state_d = ST_RESOLVE;
               chunk_d = 4'd0;
            end else begin
               bit_idx_d = bit_idx_q + 10'd1;
               state_d   = ST_ADD_B;
            end
         end
         ST_RESOLVE: begin
            if (chunk_q == LAST_CHUNK) begin
               state_d = ST_SUB;
               chunk_d = 4'd0;
               pass_d  = '0;
            end else begin
               chunk_d = chunk_q + 4'd1;
            end
         end
         ST_SUB: begin
            // sub_done is only meaningful once the last chunk has been applied.
            if (chunk_q == LAST_CHUNK) begin
               if (sub_done) begin
                  state_d = ST_DONE;
               end else if (pass_q == LAST_PASS) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  pass_d  = pass_q + 1'b1;
                  chunk_d = 4'd0;
               end
            end else begin
               chunk_d = chunk_q + 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      enable_c  = (state_q == ST_ADD_B);
      shift_c   = (state_q == ST_ADD_M);
      subtract  = (state_q == ST_SUB);
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      chunk_sel = CHUNK_IDLE;
      in_sel    = SEL_ZERO;
      case (state_q)
         ST_ADD_B:   in_sel = a_bit ? SEL_B : SEL_ZERO;
         ST_ADD_M:   in_sel = c_zero ? SEL_M : SEL_ZERO;
         ST_RESOLVE: chunk_sel = chunk_q;
         ST_SUB: begin
            chunk_sel = chunk_q;
            in_sel    = SEL_NEG_M;
         end
         default: ;
      endcase
   end

   assign bit_idx = bit_idx_q;
   assign err     = err_q;

endmodule
